xxd_line_formatter: RTL
=======================

Name: xxd_line_formatter

Overview:
Downstream consumer of the byte-sequence generator stage. Accepts a byte stream over a valid/ready handshake and emits an ASCII character stream in canonical xxd layout: offset, grouped lowercase hex, then a printable-ASCII column, terminated by '\n'. Holds one line of bytes internally for the ASCII column. Output feeds the serial/character sink.

Parameters:
BYTES_PER_LINE, 16, bytes per dump line; even, range 2..16.
OFFSET_DIGITS, 8, hex digits in the offset field; offset register width is 4*OFFSET_DIGITS.

Ports:
clk  in  1  clock; all logic is on the rising edge
rst_n  in  1  synchronous active-low reset, sampled on the clk rising edge
in_data  in  8  input byte
in_valid  in  1  in_data/in_last valid
in_last  in  1  final byte of a packet; qualified by in_valid
in_ready  out  1  byte accepted when in_valid && in_ready
out_char  out  8  ASCII character
out_valid  out  1  out_char valid
out_ready  in  1  character consumed when out_valid && out_ready
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0. State IDLE, offset 0, byte count 0. Reset mid-line abandons the line silently. No partial output follows.
- Output register: out_char/out_valid are registered. While out_valid && !out_ready, out_char is held stable. At most one character per cycle.
- in_ready is high only in HEX_WAIT, and only while the output register is empty or draining this cycle. It is never high in any other state.
- States:
  - IDLE: wait for in_valid; do not accept the byte. Go to OFFSET. An empty line is never printed.
  - OFFSET: emit OFFSET_DIGITS hex digits of offset, MSB first. Then ':' and ' '.
  - HEX_WAIT: accept a byte and store it in buffer[count].
  - HEX_HI, HEX_LO: emit the high nibble, then the low nibble.
  - After each odd byte index, emit ' '. count increments.
  - If count == BYTES_PER_LINE or in_last was accepted, go to PAD; else return to HEX_WAIT.
  - PAD: for each index from count to BYTES_PER_LINE-1, emit "  ", plus ' ' after odd indices. Then emit one extra ' '. This keeps the ASCII column aligned for partial lines.
  - ASCII: for buffer[0..count-1], emit the byte if in 0x20..0x7E, else '.'.
  - NEWLINE: emit 0x0A.
  - After NEWLINE: offset += count, modulo 2^(4*OFFSET_DIGITS), wrapping to 0. If the line ended via in_last, offset is cleared to 0. count is cleared. Go to IDLE.
- Hex digits: 0-9 map to 0x30-0x39; a-f map to 0x61-0x66.
- Full line length = OFFSET_DIGITS+2 + 2.5*BYTES_PER_LINE + 1 + BYTES_PER_LINE + 1. This is 68 characters for the defaults.
- in_last on the byte that fills the line ends that line normally and resets the offset.
- in_last with in_valid low is ignored.
- busy is the registered state != IDLE.

Optional Feature:
XXD_UPPERCASE_EN: when defined, hex nibbles a-f are emitted as 0x41-0x46 (uppercase, like xxd -u). This applies to both the offset and data fields. When undefined, they are lowercase (0x61-0x66). Layout and timing are identical either way.

Test Plan:
- Full line, out_ready=1: send 01 01 02 03 05 08 0d 15 22 37 59 90 e9 79 62 db. Expect exactly the line `00000000: 0101 0203 0508 0d15 2237 5990 e979 62db  ........"7Y..yb.` followed by 0x0A. That is 68 chars, then busy=0.
- Offset advance: 20 bytes of 0x41, no in_last. Expect the second line to begin "00000010: 4141 4141". No ASCII/newline for the second line until 16 bytes arrive.
- Partial line: send 41 42 43 with in_last on 0x43. Expect "00000000: 4142 43", then 34 spaces, then "ABC\n" (55 chars). The next packet restarts at "00000000: ".
- Backpressure: random out_ready at 30% duty during the full-line test. out_char must never change while out_valid && !out_ready. The character sequence must be unchanged, and in_ready must be low throughout backpressured output.
- Reset mid-line: assert rst_n=0 for 1 cycle after 5 bytes. The next cycle has out_valid=0, in_ready=0, busy=0. A new byte 0x7E then yields a line starting "00000000: 7e".
- Macro/wrap: with XXD_UPPERCASE_EN defined and offset preloaded to near-wrap by streaming 0xFFFFFFF0 bytes (or OFFSET_DIGITS=2, 256+16 bytes): expect data hex "E979" uppercase. The offset field wraps to "00000000:" (or "00:").

Source files
------------

// File: rtl/xxd_line_formatter.sv
// Byte stream to xxd-style text: offset, grouped hex, ASCII column, newline.
// Define XXD_UPPERCASE_EN to emit hex letters as A-F instead of a-f.
module xxd_line_formatter #(
  parameter int BYTES_PER_LINE = 16,
  parameter int OFFSET_DIGITS  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int OW = 4 * OFFSET_DIGITS;
  localparam int CW = $clog2(BYTES_PER_LINE + 1);
  localparam int IW = $clog2(BYTES_PER_LINE);
  localparam logic [CW-1:0] LINE_CNT = CW'(BYTES_PER_LINE);

  typedef enum logic [3:0] {
    S_IDLE, S_OFFSET, S_HEX_WAIT, S_HEX_HI, S_HEX_LO,
    S_HEX_SP, S_PAD, S_ASCII, S_NEWLINE
  } state_t;

  state_t        r_state;
  logic [OW-1:0] r_offset;
  logic [CW-1:0] r_count;
  logic [7:0]    r_idx;
  logic          r_last;
  logic [7:0]    r_byte;
  logic [7:0]    r_out_char;
  logic          r_out_valid;
  logic [7:0]    r_buf [BYTES_PER_LINE];

  logic          w_out_free;
  logic          w_accept;
  logic          w_emit;
  logic [7:0]    w_emit_char;
  logic [3:0]    w_off_nib;
  logic [7:0]    w_pad_last;
  logic [7:0]    w_buf_rd;
  logic [CW-1:0] w_cnt_inc;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
`ifdef XXD_UPPERCASE_EN
    return 8'h37 + {4'h0, n};
`else
    return 8'h57 + {4'h0, n};
`endif
  endfunction

  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = (r_state == S_HEX_WAIT) && w_out_free;
  assign w_accept   = in_valid && in_ready;
  assign w_cnt_inc  = r_count + 1'b1;
  assign w_buf_rd   = r_buf[r_idx[IW-1:0]];
  assign out_char   = r_out_char;
  assign out_valid  = r_out_valid;
  assign busy       = (r_state != S_IDLE);

  // r_idx counts offset digits most-significant first.
  always_comb begin
    w_off_nib = 4'h0;
    for (int i = 0; i < OFFSET_DIGITS; i++)
      if (r_idx == 8'(OFFSET_DIGITS - 1 - i))
        w_off_nib = r_offset[4*i +: 4];
  end

  // Blank columns left by missing bytes, plus the separator before ASCII; stored as last index.
  always_comb begin
    w_pad_last = 8'(2 * (BYTES_PER_LINE - int'(r_count)) + BYTES_PER_LINE / 2
                    - int'(r_count >> 1));
  end

  always_comb begin
    w_emit      = 1'b1;
    w_emit_char = 8'h20;
    case (r_state)
      S_OFFSET: begin
        if (r_idx < 8'(OFFSET_DIGITS))
          w_emit_char = hex_char(w_off_nib);
        else if (r_idx == 8'(OFFSET_DIGITS))
          w_emit_char = 8'h3A;
      end
      S_HEX_HI:  w_emit_char = hex_char(r_byte[7:4]);
      S_HEX_LO:  w_emit_char = hex_char(r_byte[3:0]);
      S_HEX_SP,
      S_PAD:     w_emit_char = 8'h20;
      S_ASCII:   w_emit_char = (w_buf_rd >= 8'h20 && w_buf_rd <= 8'h7E) ? w_buf_rd : 8'h2E;
      S_NEWLINE: w_emit_char = 8'h0A;
      default:   w_emit      = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept)
      r_buf[r_count[IW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_offset    <= '0;
      r_count     <= '0;
      r_idx       <= '0;
      r_last      <= 1'b0;
      r_byte      <= '0;
      r_out_char  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (out_ready)
        r_out_valid <= 1'b0;
      if (w_emit && w_out_free) begin
        r_out_char  <= w_emit_char;
        r_out_valid <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= S_OFFSET;
            r_idx   <= '0;
          end
        end
        S_OFFSET: begin
          if (w_out_free) begin
            r_idx <= r_idx + 8'd1;
            if (r_idx == 8'(OFFSET_DIGITS + 1))
              r_state <= S_HEX_WAIT;
          end
        end
        S_HEX_WAIT: begin
          if (w_accept) begin
            r_byte  <= in_data;
            r_last  <= in_last;
            r_state <= S_HEX_HI;
          end
        end
        S_HEX_HI: begin
          if (w_out_free)
            r_state <= S_HEX_LO;
        end
        S_HEX_LO: begin
          if (w_out_free) begin
            r_count <= w_cnt_inc;
            // An even index can only end the line through in_last, since lines are even length.
            if (r_count[0])
              r_state <= S_HEX_SP;
            else if (r_last) begin
              r_state <= S_PAD;
              r_idx   <= '0;
            end else
              r_state <= S_HEX_WAIT;
          end
        end
        S_HEX_SP: begin
          if (w_out_free) begin
            if (r_count == LINE_CNT || r_last) begin
              r_state <= S_PAD;
              r_idx   <= '0;
            end else
              r_state <= S_HEX_WAIT;
          end
        end
        S_PAD: begin
          if (w_out_free) begin
            if (r_idx == w_pad_last) begin
              r_state <= S_ASCII;
              r_idx   <= '0;
            end else
              r_idx <= r_idx + 8'd1;
          end
        end
        S_ASCII: begin
          if (w_out_free) begin
            if (r_idx + 8'd1 == 8'(r_count))
              r_state <= S_NEWLINE;
            else
              r_idx <= r_idx + 8'd1;
          end
        end
        S_NEWLINE: begin
          if (w_out_free) begin
            r_offset <= r_last ? '0 : r_offset + OW'(r_count);
            r_count  <= '0;
            r_last   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
